pipe_hazard_cu: RTL and testbench

//  Pipelined control unit for the five-stage MIPS core: decodes the ID-stage instruction, carries control

---
 rtl/pipe_hazard_cu.sv | 387 ++++++++++++++++++++++++++++++++++++++
 tb/tb_pipe_hazard_cu.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_cu.sv
// pipe_hazard_cu: pipelined control unit of a five-stage MIPS core.
// Decodes the ID-stage instruction, carries control through the ID/EX,
// EX/MEM and MEM/WB registers, detects RAW hazards, and drives the operand
// forward selects and the PC / IF-ID stall. Branches resolve in ID with one
// delay slot; z is the equality compare of the forwarded operands.
module pipe_hazard_cu #(
   parameter int REG_AW  = 5,
   parameter int FWD_EN  = 1,
   parameter int EXT_ISA = 0,
   parameter int CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [5:0]        op,
   input  logic [5:0]        func,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   input  logic              z,
   output logic [1:0]        pcsource,
   output logic              wpcir,
   output logic [1:0]        fwda,
   output logic [1:0]        fwdb,
   output logic              sext,
   output logic              illegal,
   output logic              ewreg,
   output logic              em2reg,
   output logic              ewmem,
   output logic              ealuimm,
   output logic              eshift,
   output logic              ejal,
   output logic [3:0]        ealuc,
   output logic [REG_AW-1:0] ern,
   output logic              mwreg,
   output logic              mm2reg,
   output logic              mwmem,
   output logic [REG_AW-1:0] mrn,
   output logic              wwreg,
   output logic              wm2reg,
   output logic [REG_AW-1:0] wrn,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // A stage that writes register x creates a dependency, except writes to $0.
   function automatic logic hit(input logic wr, input logic [REG_AW-1:0] rn,
                                input logic [REG_AW-1:0] x);
      return wr && (rn != {REG_AW{1'b0}}) && (rn == x);
   endfunction

   // ID decode results
   logic              id_legal_s;
   logic              id_wreg_s;
   logic              id_m2reg_s;
   logic              id_wmem_s;
   logic              id_aluimm_s;
   logic              id_shift_s;
   logic              id_jal_s;
   logic [3:0]        id_aluc_s;
   logic              id_sext_s;
   logic              id_use_rs_s;
   logic              id_use_rt_s;
   logic              id_beq_s;
   logic              id_bne_s;
   logic              id_jmp_s;
   logic              id_jr_s;
   logic [REG_AW-1:0] id_rn_s;

   // Hazard / forwarding
   logic              hit_e_rs_s;
   logic              hit_e_rt_s;
   logic              hit_m_rs_s;
   logic              hit_m_rt_s;
   logic              stall_s;
   logic [1:0]        fwda_s;
   logic [1:0]        fwdb_s;
   logic [1:0]        pcsource_s;

   // Pipeline registers
   logic              ewreg_d, ewreg_q;
   logic              em2reg_d, em2reg_q;
   logic              ewmem_d, ewmem_q;
   logic              ealuimm_d, ealuimm_q;
   logic              eshift_d, eshift_q;
   logic              ejal_d, ejal_q;
   logic [3:0]        ealuc_d, ealuc_q;
   logic [REG_AW-1:0] ern_d, ern_q;
   logic              mwreg_d, mwreg_q;
   logic              mm2reg_d, mm2reg_q;
   logic              mwmem_d, mwmem_q;
   logic [REG_AW-1:0] mrn_d, mrn_q;
   logic              wwreg_d, wwreg_q;
   logic              wm2reg_d, wm2reg_q;
   logic [REG_AW-1:0] wrn_d, wrn_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

   // Instruction decode: unknown encodings leave everything off (a nop) with legal low.
   always_comb begin
      id_legal_s  = 1'b0;
      id_wreg_s   = 1'b0;
      id_m2reg_s  = 1'b0;
      id_wmem_s   = 1'b0;
      id_aluimm_s = 1'b0;
      id_shift_s  = 1'b0;
      id_jal_s    = 1'b0;
      id_aluc_s   = 4'b0000;
      id_sext_s   = 1'b1;
      id_use_rs_s = 1'b0;
      id_use_rt_s = 1'b0;
      id_beq_s    = 1'b0;
      id_bne_s    = 1'b0;
      id_jmp_s    = 1'b0;
      id_jr_s     = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0000;
                  id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_SUB: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0100;
                  id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_AND: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0001;
                  id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_OR: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0101;
                  id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_XOR: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0010;
                  id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_SLL: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0011;
                  id_shift_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_SRL: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b0111;
                  id_shift_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_SRA: begin
                  id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b1111;
                  id_shift_s = 1'b1; id_use_rt_s = 1'b1;
               end
               FN_JR: begin
                  id_legal_s = 1'b1; id_jr_s = 1'b1; id_use_rs_s = 1'b1;
               end
               FN_SLT: begin
                  if (EXT_ISA != 0) begin
                     id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluc_s = 4'b1000;
                     id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
                  end else begin
                     id_legal_s = 1'b0;
                  end
               end
               default: id_legal_s = 1'b0;
            endcase
         end
         OP_ADDI: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0000; id_use_rs_s = 1'b1;
         end
         OP_ANDI: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0001; id_sext_s = 1'b0; id_use_rs_s = 1'b1;
         end
         OP_ORI: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0101; id_sext_s = 1'b0; id_use_rs_s = 1'b1;
         end
         OP_XORI: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0010; id_sext_s = 1'b0; id_use_rs_s = 1'b1;
         end
         OP_LW: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_m2reg_s = 1'b1;
            id_aluimm_s = 1'b1; id_aluc_s = 4'b0000; id_use_rs_s = 1'b1;
         end
         OP_SW: begin
            id_legal_s = 1'b1; id_wmem_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0000; id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
         end
         OP_BEQ: begin
            id_legal_s = 1'b1; id_beq_s = 1'b1; id_aluc_s = 4'b0000;
            id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
         end
         OP_BNE: begin
            id_legal_s = 1'b1; id_bne_s = 1'b1; id_aluc_s = 4'b0000;
            id_use_rs_s = 1'b1; id_use_rt_s = 1'b1;
         end
         OP_LUI: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_aluimm_s = 1'b1;
            id_aluc_s = 4'b0110;
         end
         OP_J: begin
            id_legal_s = 1'b1; id_jmp_s = 1'b1;
         end
         OP_JAL: begin
            id_legal_s = 1'b1; id_wreg_s = 1'b1; id_jal_s = 1'b1; id_jmp_s = 1'b1;
         end
         default: id_legal_s = 1'b0;
      endcase
   end

   // Destination register: jal links into the top register, R-type uses rd, I-type rt.
   always_comb begin
      if (op == OP_JAL) begin
         id_rn_s = {REG_AW{1'b1}};
      end else if (op == OP_RTYPE) begin
         id_rn_s = rd;
      end else begin
         id_rn_s = rt;
      end
   end

   // RAW hazard detection, forward selects and stall decision.
   always_comb begin
      hit_e_rs_s = hit(ewreg_q, ern_q, rs);
      hit_e_rt_s = hit(ewreg_q, ern_q, rt);
      hit_m_rs_s = hit(mwreg_q, mrn_q, rs);
      hit_m_rt_s = hit(mwreg_q, mrn_q, rt);
      fwda_s     = 2'b00;
      fwdb_s     = 2'b00;
      stall_s    = 1'b0;
      if (FWD_EN != 0) begin
         // EX result is the youngest value so it wins over MEM; a load in EX has no data yet.
         if (hit_e_rs_s && !em2reg_q) begin
            fwda_s = 2'b01;
         end else if (hit_m_rs_s) begin
            fwda_s = mm2reg_q ? 2'b11 : 2'b10;
         end else begin
            fwda_s = 2'b00;
         end
         if (hit_e_rt_s && !em2reg_q) begin
            fwdb_s = 2'b01;
         end else if (hit_m_rt_s) begin
            fwdb_s = mm2reg_q ? 2'b11 : 2'b10;
         end else begin
            fwdb_s = 2'b00;
         end
         stall_s = em2reg_q && ((hit_e_rs_s && id_use_rs_s) || (hit_e_rt_s && id_use_rt_s));
      end else begin
         stall_s = ((hit_e_rs_s || hit_m_rs_s) && id_use_rs_s) ||
                   ((hit_e_rt_s || hit_m_rt_s) && id_use_rt_s);
      end
   end

   // Next-PC source; a stalled branch is re-evaluated once its operands are ready.
   always_comb begin
      if (stall_s) begin
         pcsource_s = 2'b00;
      end else if ((id_beq_s && z) || (id_bne_s && !z) || id_jmp_s) begin
         pcsource_s = 2'b01;
      end else if (id_jr_s) begin
         pcsource_s = 2'b10;
      end else begin
         pcsource_s = 2'b00;
      end
   end

   // Next pipeline contents: EX takes the decode or a bubble, MEM and WB shift along.
   always_comb begin
      if (stall_s || !id_legal_s) begin
         ewreg_d   = 1'b0;
         em2reg_d  = 1'b0;
         ewmem_d   = 1'b0;
         ealuimm_d = 1'b0;
         eshift_d  = 1'b0;
         ejal_d    = 1'b0;
         ealuc_d   = 4'b0000;
         ern_d     = {REG_AW{1'b0}};
      end else begin
         ewreg_d   = id_wreg_s;
         em2reg_d  = id_m2reg_s;
         ewmem_d   = id_wmem_s;
         ealuimm_d = id_aluimm_s;
         eshift_d  = id_shift_s;
         ejal_d    = id_jal_s;
         ealuc_d   = id_aluc_s;
         ern_d     = id_rn_s;
      end
      mwreg_d  = ewreg_q;
      mm2reg_d = em2reg_q;
      mwmem_d  = ewmem_q;
      mrn_d    = ern_q;
      wwreg_d  = mwreg_q;
      wm2reg_d = mm2reg_q;
      wrn_d    = mrn_q;
      if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Pipeline and stall-counter registers; reset clears everything, overriding a stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         ewreg_q     <= 1'b0;
         em2reg_q    <= 1'b0;
         ewmem_q     <= 1'b0;
         ealuimm_q   <= 1'b0;
         eshift_q    <= 1'b0;
         ejal_q      <= 1'b0;
         ealuc_q     <= 4'b0000;
         ern_q       <= {REG_AW{1'b0}};
         mwreg_q     <= 1'b0;
         mm2reg_q    <= 1'b0;
         mwmem_q     <= 1'b0;
         mrn_q       <= {REG_AW{1'b0}};
         wwreg_q     <= 1'b0;
         wm2reg_q    <= 1'b0;
         wrn_q       <= {REG_AW{1'b0}};
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ewreg_q     <= ewreg_d;
         em2reg_q    <= em2reg_d;
         ewmem_q     <= ewmem_d;
         ealuimm_q   <= ealuimm_d;
         eshift_q    <= eshift_d;
         ejal_q      <= ejal_d;
         ealuc_q     <= ealuc_d;
         ern_q       <= ern_d;
         mwreg_q     <= mwreg_d;
         mm2reg_q    <= mm2reg_d;
         mwmem_q     <= mwmem_d;
         mrn_q       <= mrn_d;
         wwreg_q     <= wwreg_d;
         wm2reg_q    <= wm2reg_d;
         wrn_q       <= wrn_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pcsource  = pcsource_s;
   assign wpcir     = ~stall_s;
   assign fwda      = fwda_s;
   assign fwdb      = fwdb_s;
   assign sext      = id_sext_s;
   assign illegal   = ~id_legal_s;
   assign ewreg     = ewreg_q;
   assign em2reg    = em2reg_q;
   assign ewmem     = ewmem_q;
   assign ealuimm   = ealuimm_q;
   assign eshift    = eshift_q;
   assign ejal      = ejal_q;
   assign ealuc     = ealuc_q;
   assign ern       = ern_q;
   assign mwreg     = mwreg_q;
   assign mm2reg    = mm2reg_q;
   assign mwmem     = mwmem_q;
   assign mrn       = mrn_q;
   assign wwreg     = wwreg_q;
   assign wm2reg    = wm2reg_q;
   assign wrn       = wrn_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_cu.sv
// Testbench for pipe_hazard_cu: two instances share one instruction stream,
// u0 with forwarding + slt and a 16-bit counter, u1 without forwarding, no slt
// and a 2-bit counter. A table-driven instruction model predicts every cycle.
module tb_pipe_hazard_cu;

   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] aluc;
      logic [2:0] br;     // 0 none, 1 beq, 2 bne, 3 j/jal, 4 jr
      logic       legal;
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic       aluimm;
      logic       shift;
      logic       jal;
      logic       sext;
      logic       urs;
      logic       urt;
      logic       ext;
   } ins_t;

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic       aluimm;
      logic       shift;
      logic       jal;
      logic [3:0] aluc;
      logic [4:0] rn;
   } es_t;

   typedef struct packed {
      logic [1:0]  pcsource;
      logic        wpcir;
      logic [1:0]  fwda;
      logic [1:0]  fwdb;
      logic        sext;
      logic        illegal;
      es_t         e;
      logic        mwreg;
      logic        mm2reg;
      logic        mwmem;
      logic [4:0]  mrn;
      logic        wwreg;
      logic        wm2reg;
      logic [4:0]  wrn;
      logic [15:0] cnt;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] func = 6'd0;
   logic [4:0] rs = 5'd0;
   logic [4:0] rt = 5'd0;
   logic [4:0] rd = 5'd0;
   logic       z = 1'b0;

   logic [1:0] a_pcsource, a_fwda, a_fwdb, b_pcsource, b_fwda, b_fwdb;
   logic       a_wpcir, a_sext, a_illegal, b_wpcir, b_sext, b_illegal;
   logic       a_ewreg, a_em2reg, a_ewmem, a_ealuimm, a_eshift, a_ejal;
   logic       b_ewreg, b_em2reg, b_ewmem, b_ealuimm, b_eshift, b_ejal;
   logic [3:0] a_ealuc, b_ealuc;
   logic [4:0] a_ern, a_mrn, a_wrn, b_ern, b_mrn, b_wrn;
   logic       a_mwreg, a_mm2reg, a_mwmem, a_wwreg, a_wm2reg;
   logic       b_mwreg, b_mm2reg, b_mwmem, b_wwreg, b_wm2reg;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   pipe_hazard_cu #(.REG_AW(5), .FWD_EN(1), .EXT_ISA(1), .CNT_W(16)) u0 (
      .clock(clock), .reset(reset), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .z(z),
      .pcsource(a_pcsource), .wpcir(a_wpcir), .fwda(a_fwda), .fwdb(a_fwdb), .sext(a_sext),
      .illegal(a_illegal), .ewreg(a_ewreg), .em2reg(a_em2reg), .ewmem(a_ewmem),
      .ealuimm(a_ealuimm), .eshift(a_eshift), .ejal(a_ejal), .ealuc(a_ealuc), .ern(a_ern),
      .mwreg(a_mwreg), .mm2reg(a_mm2reg), .mwmem(a_mwmem), .mrn(a_mrn),
      .wwreg(a_wwreg), .wm2reg(a_wm2reg), .wrn(a_wrn), .stall_cnt(a_cnt));

   pipe_hazard_cu #(.REG_AW(5), .FWD_EN(0), .EXT_ISA(0), .CNT_W(2)) u1 (
      .clock(clock), .reset(reset), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .z(z),
      .pcsource(b_pcsource), .wpcir(b_wpcir), .fwda(b_fwda), .fwdb(b_fwdb), .sext(b_sext),
      .illegal(b_illegal), .ewreg(b_ewreg), .em2reg(b_em2reg), .ewmem(b_ewmem),
      .ealuimm(b_ealuimm), .eshift(b_eshift), .ejal(b_ejal), .ealuc(b_ealuc), .ern(b_ern),
      .mwreg(b_mwreg), .mm2reg(b_mm2reg), .mwmem(b_mwmem), .mrn(b_mrn),
      .wwreg(b_wwreg), .wm2reg(b_wm2reg), .wrn(b_wrn), .stall_cnt(b_cnt));

   always #5 clock = ~clock;

   ins_t tab [0:22];
   es_t  e_st [0:1];
   es_t  m_st [0:1];
   es_t  w_st [0:1];
   int   cnt_st [0:1];
   obs_t q0 [$];
   obs_t q1 [$];
   int   checks = 0;
   int   errors = 0;

   // Table columns: op fn aluc br legal wreg m2reg wmem aluimm shift jal sext urs urt ext
   function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input logic [3:0] al,
                               input int br, input bit [10:0] fl);
      ins_t t;
      t.op = o; t.fn = f; t.aluc = al; t.br = 3'(br);
      {t.legal, t.wreg, t.m2reg, t.wmem, t.aluimm, t.shift, t.jal, t.sext, t.urs, t.urt, t.ext} = fl;
      return t;
   endfunction

   task automatic init_tab();
      //                                          lg w m2 wm im sh jl sx rs rt ex
      tab[0]  = mk(6'b000000, 6'b100000, 4'b0000, 0, 11'b1_1_0_0_0_0_0_1_1_1_0); // add
      tab[1]  = mk(6'b000000, 6'b100010, 4'b0100, 0, 11'b1_1_0_0_0_0_0_1_1_1_0); // sub
      tab[2]  = mk(6'b000000, 6'b100100, 4'b0001, 0, 11'b1_1_0_0_0_0_0_1_1_1_0); // and
      tab[3]  = mk(6'b000000, 6'b100101, 4'b0101, 0, 11'b1_1_0_0_0_0_0_1_1_1_0); // or
      tab[4]  = mk(6'b000000, 6'b100110, 4'b0010, 0, 11'b1_1_0_0_0_0_0_1_1_1_0); // xor
      tab[5]  = mk(6'b000000, 6'b000000, 4'b0011, 0, 11'b1_1_0_0_0_1_0_1_0_1_0); // sll
      tab[6]  = mk(6'b000000, 6'b000010, 4'b0111, 0, 11'b1_1_0_0_0_1_0_1_0_1_0); // srl
      tab[7]  = mk(6'b000000, 6'b000011, 4'b1111, 0, 11'b1_1_0_0_0_1_0_1_0_1_0); // sra
      tab[8]  = mk(6'b000000, 6'b001000, 4'b0000, 4, 11'b1_0_0_0_0_0_0_1_1_0_0); // jr
      tab[9]  = mk(6'b001000, 6'b000000, 4'b0000, 0, 11'b1_1_0_0_1_0_0_1_1_0_0); // addi
      tab[10] = mk(6'b001100, 6'b000000, 4'b0001, 0, 11'b1_1_0_0_1_0_0_0_1_0_0); // andi
      tab[11] = mk(6'b001101, 6'b000000, 4'b0101, 0, 11'b1_1_0_0_1_0_0_0_1_0_0); // ori
      tab[12] = mk(6'b001110, 6'b000000, 4'b0010, 0, 11'b1_1_0_0_1_0_0_0_1_0_0); // xori
      tab[13] = mk(6'b100011, 6'b000000, 4'b0000, 0, 11'b1_1_1_0_1_0_0_1_1_0_0); // lw
      tab[14] = mk(6'b101011, 6'b000000, 4'b0000, 0, 11'b1_0_0_1_1_0_0_1_1_1_0); // sw
      tab[15] = mk(6'b000100, 6'b000000, 4'b0000, 1, 11'b1_0_0_0_0_0_0_1_1_1_0); // beq
      tab[16] = mk(6'b000101, 6'b000000, 4'b0000, 2, 11'b1_0_0_0_0_0_0_1_1_1_0); // bne
      tab[17] = mk(6'b001111, 6'b000000, 4'b0110, 0, 11'b1_1_0_0_1_0_0_1_0_0_0); // lui
      tab[18] = mk(6'b000010, 6'b000000, 4'b0000, 3, 11'b1_0_0_0_0_0_0_1_0_0_0); // j
      tab[19] = mk(6'b000011, 6'b000000, 4'b0000, 3, 11'b1_1_0_0_0_0_1_1_0_0_0); // jal
      tab[20] = mk(6'b000000, 6'b101010, 4'b1000, 0, 11'b1_1_0_0_0_0_0_1_1_1_1); // slt
      tab[21] = mk(6'b111111, 6'b000000, 4'b0000, 0, 11'b0_0_0_0_0_0_0_1_0_0_0); // bad op
      tab[22] = mk(6'b000000, 6'b111111, 4'b0000, 0, 11'b0_0_0_0_0_0_0_1_0_0_0); // bad func
   endtask

   function automatic bit writes(input es_t s, input int x);
      return s.wreg && (s.rn != 5'd0) && (int'(s.rn) == x);
   endfunction

   // Operand source: youngest non-load producer first, else MEM (ALU or load data), else regfile.
   function automatic logic [1:0] src(input bit eh, input bit el, input bit mh, input bit ml);
      if (eh && !el) return 2'b01;
      if (mh) return ml ? 2'b11 : 2'b10;
      return 2'b00;
   endfunction

   // Reference model for config c (0: forwarding+slt, 16-bit count; 1: no forwarding, 2-bit count).
   task automatic model(input int c, input int k, input int a, input int b, input int d,
                        input bit zz, input bit rst);
      ins_t t;
      es_t  dec;
      obs_t x;
      bit   legal, urs, urt, ers, ert, mrs, mrt, stall;
      int   cmax;
      t     = tab[k];
      legal = t.legal && (!t.ext || c == 0);
      urs   = legal && t.urs;
      urt   = legal && t.urt;
      ers   = writes(e_st[c], a);
      ert   = writes(e_st[c], b);
      mrs   = writes(m_st[c], a);
      mrt   = writes(m_st[c], b);
      cmax  = (c == 0) ? 65535 : 3;
      x     = '0;
      if (c == 0) begin
         stall  = e_st[c].m2reg && ((ers && urs) || (ert && urt));
         x.fwda = src(ers, e_st[c].m2reg, mrs, m_st[c].m2reg);
         x.fwdb = src(ert, e_st[c].m2reg, mrt, m_st[c].m2reg);
      end else begin
         stall = ((ers || mrs) && urs) || ((ert || mrt) && urt);
      end
      x.wpcir = !stall;
      if (stall) x.pcsource = 2'b00;
      else if (legal && ((t.br == 3'd1 && zz) || (t.br == 3'd2 && !zz) || t.br == 3'd3)) x.pcsource = 2'b01;
      else if (legal && t.br == 3'd4) x.pcsource = 2'b10;
      else x.pcsource = 2'b00;
      x.sext    = legal ? t.sext : 1'b1;
      x.illegal = !legal;
      x.e       = e_st[c];
      x.mwreg   = m_st[c].wreg;
      x.mm2reg  = m_st[c].m2reg;
      x.mwmem   = m_st[c].wmem;
      x.mrn     = m_st[c].rn;
      x.wwreg   = w_st[c].wreg;
      x.wm2reg  = w_st[c].m2reg;
      x.wrn     = w_st[c].rn;
      x.cnt     = 16'(cnt_st[c]);
      if (c == 0) q0.push_back(x); else q1.push_back(x);
      // advance one clock
      dec = {t.wreg, t.m2reg, t.wmem, t.aluimm, t.shift, t.jal, t.aluc,
             5'(t.jal ? 31 : (t.op == 6'd0 ? d : b))};
      if (rst) begin
         e_st[c] = '0; m_st[c] = '0; w_st[c] = '0; cnt_st[c] = 0;
      end else begin
         w_st[c] = m_st[c];
         m_st[c] = e_st[c];
         e_st[c] = (stall || !legal) ? es_t'(0) : dec;
         if (stall && cnt_st[c] < cmax) cnt_st[c] = cnt_st[c] + 1;
      end
   endtask

   task automatic issue(input int k, input int a, input int b, input int d, input bit zz, input bit rst);
      @(posedge clock);
      #1;
      reset = rst;
      op    = tab[k].op;
      func  = (tab[k].op == 6'd0) ? tab[k].fn : 6'($urandom_range(0, 63));
      rs    = 5'(a);
      rt    = 5'(b);
      rd    = 5'(d);
      z     = zz;
      model(0, k, a, b, d, zz, rst);
      model(1, k, a, b, d, zz, rst);
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s u%0d t=%0t: got %0h expected %0h", nm, c, $time, act, exp);
      end
   endtask

   task automatic cmp(input int c, input obs_t a, input obs_t e);
      chk("pcsource", c, a.pcsource, e.pcsource);
      chk("wpcir", c, a.wpcir, e.wpcir);
      chk("fwda", c, a.fwda, e.fwda);
      chk("fwdb", c, a.fwdb, e.fwdb);
      chk("sext", c, a.sext, e.sext);
      chk("illegal", c, a.illegal, e.illegal);
      chk("ewreg", c, a.e.wreg, e.e.wreg);
      chk("em2reg", c, a.e.m2reg, e.e.m2reg);
      chk("ewmem", c, a.e.wmem, e.e.wmem);
      chk("ealuimm", c, a.e.aluimm, e.e.aluimm);
      chk("eshift", c, a.e.shift, e.e.shift);
      chk("ejal", c, a.e.jal, e.e.jal);
      chk("ealuc", c, a.e.aluc, e.e.aluc);
      chk("ern", c, a.e.rn, e.e.rn);
      chk("mwreg", c, a.mwreg, e.mwreg);
      chk("mm2reg", c, a.mm2reg, e.mm2reg);
      chk("mwmem", c, a.mwmem, e.mwmem);
      chk("mrn", c, a.mrn, e.mrn);
      chk("wwreg", c, a.wwreg, e.wwreg);
      chk("wm2reg", c, a.wm2reg, e.wm2reg);
      chk("wrn", c, a.wrn, e.wrn);
      chk("stall_cnt", c, a.cnt, e.cnt);
   endtask

   // Monitor: every falling edge, compare each DUT against the oldest pending expectation.
   initial begin
      obs_t ex, ac;
      forever begin
         @(negedge clock);
         if (q0.size() > 0) begin
            ex = q0.pop_front();
            ac = {a_pcsource, a_wpcir, a_fwda, a_fwdb, a_sext, a_illegal,
                  a_ewreg, a_em2reg, a_ewmem, a_ealuimm, a_eshift, a_ejal, a_ealuc, a_ern,
                  a_mwreg, a_mm2reg, a_mwmem, a_mrn, a_wwreg, a_wm2reg, a_wrn, a_cnt};
            cmp(0, ac, ex);
         end
         if (q1.size() > 0) begin
            ex = q1.pop_front();
            ac = {b_pcsource, b_wpcir, b_fwda, b_fwdb, b_sext, b_illegal,
                  b_ewreg, b_em2reg, b_ewmem, b_ealuimm, b_eshift, b_ejal, b_ealuc, b_ern,
                  b_mwreg, b_mm2reg, b_mwmem, b_mrn, b_wwreg, b_wm2reg, b_wrn, {14'd0, b_cnt}};
            cmp(1, ac, ex);
         end
      end
   end

   function automatic int pick_reg();
      int r;
      r = int'($urandom_range(0, 5));
      return (r == 5) ? 31 : r;
   endfunction

   // Stimulus: reset, directed hazard scenarios, then a random instruction stream.
   initial begin
      init_tab();
      for (int c = 0; c < 2; c++) begin
         e_st[c] = '0; m_st[c] = '0; w_st[c] = '0; cnt_st[c] = 0;
      end
      repeat (2) @(posedge clock);
      // add $3,$1,$2 ; sub $4,$3,$1
      issue(0, 1, 2, 3, 1'b0, 1'b0);
      issue(1, 3, 1, 4, 1'b0, 1'b0);
      issue(5, 0, 0, 0, 1'b0, 1'b0);
      // lw $5,0($1) ; add $6,$5,$2 held in ID while stalled
      issue(13, 1, 5, 0, 1'b0, 1'b0);
      issue(0, 5, 2, 6, 1'b0, 1'b0);
      issue(0, 5, 2, 6, 1'b0, 1'b0);
      issue(5, 0, 0, 0, 1'b0, 1'b0);
      // add $3 ; or $4,$3,$3 (u1 stalls twice)
      issue(0, 1, 2, 3, 1'b0, 1'b0);
      issue(3, 3, 3, 4, 1'b0, 1'b0);
      issue(3, 3, 3, 4, 1'b0, 1'b0);
      issue(3, 3, 3, 4, 1'b0, 1'b0);
      // lw $7 ; beq $7,$7 z=1 ; jal
      issue(13, 1, 7, 0, 1'b0, 1'b0);
      issue(15, 7, 7, 0, 1'b1, 1'b0);
      issue(15, 7, 7, 0, 1'b1, 1'b0);
      issue(19, 0, 0, 0, 1'b0, 1'b0);
      issue(5, 0, 0, 0, 1'b0, 1'b0);
      // writes to $0, then illegal opcode, slt
      issue(9, 0, 0, 0, 1'b0, 1'b0);
      issue(0, 0, 0, 1, 1'b0, 1'b0);
      issue(21, 1, 2, 3, 1'b0, 1'b0);
      issue(20, 1, 2, 3, 1'b0, 1'b0);
      issue(5, 0, 0, 0, 1'b0, 1'b0);
      // reset during load-use stall
      issue(13, 1, 5, 0, 1'b0, 1'b0);
      issue(0, 5, 2, 6, 1'b0, 1'b1);
      issue(0, 5, 2, 6, 1'b0, 1'b0);
      issue(5, 0, 0, 0, 1'b0, 1'b0);
      // random stream
      for (int n = 0; n < 600; n++) begin
         issue(int'($urandom_range(0, 22)), pick_reg(), pick_reg(), pick_reg(),
               1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      end
      repeat (3) @(negedge clock);
      chk("queue_drain", 0, 32'(q0.size() + q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
